hexdisp_scan: RTL and testbench

//  Time-multiplexed driver for an NDIG-digit hex 7-segment display; shows the
//  32-bit key-entry buffer value. Digit 0 (rightmost) shows value[3:0], so the

---
 rtl/hexdisp_pkg.sv | 19 +
 rtl/seg7_dec.sv | 15 +
 rtl/hexdisp_scan.sv | 105 ++++++++++
 tb/tb_hexdisp_scan.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/hexdisp_pkg.sv
// Shared constants for the hex 7-segment scanner: segment bit positions and the
// nibble-to-segment table (a..g on bits 0..6, active-high).
package hexdisp_pkg;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  localparam logic [6:0] SEG7_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/seg7_dec.sv
// Combinational nibble to {dp,g..a} decoder; the decimal point is never lit.
module seg7_dec
  import hexdisp_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [7:0] seg_o
);

  always_comb begin
    seg_o               = '0;
    seg_o[SEG_G:SEG_A]  = SEG7_TABLE[nib_i];
    seg_o[SEG_DP]       = 1'b0;
  end

endmodule

// File: rtl/hexdisp_scan.sv
// Time-multiplexed NDIG-digit hex display driver with a per-frame input snapshot.
// Optional leading-zero blanking is built when HEXDISP_LZB_EN is defined.
module hexdisp_scan
  import hexdisp_pkg::*;
#(
  parameter int NDIG  = 8,
  parameter int DIV   = 1000,
  parameter int GUARD = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [4*NDIG-1:0] value,
  input  logic              enable,
  output logic [NDIG-1:0]   dig_sel,
  output logic [7:0]        seg,
  output logic              frame_start
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int DW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(DIV - 1);
  localparam logic [DW-1:0] D_LAST = DW'(NDIG - 1);

  logic [PW-1:0]     p_q, p_d;
  logic [DW-1:0]     d_q, d_d;
  logic [4*NDIG-1:0] shadow_q, shadow_d;
  logic [NDIG-1:0]   dig_sel_q, dig_sel_d;
  logic [7:0]        seg_q, seg_d;
  logic              frame_start_q, frame_start_d;

  logic [3:0] nib;
  logic [7:0] nib_seg;
  logic       in_guard;
  logic       lzb_blank;

  assign nib      = 4'(shadow_q >> {d_q, 2'b00});
  assign in_guard = (int'(p_q) < GUARD);

  seg7_dec u_dec (
    .nib_i (nib),
    .seg_o (nib_seg)
  );

`ifdef HEXDISP_LZB_EN
  // Blank a digit when it and every digit to its left are zero; digit 0 always shows.
  assign lzb_blank = (d_q != '0) && ((shadow_q >> {d_q, 2'b00}) == '0);
`else
  assign lzb_blank = 1'b0;
`endif

  always_comb begin
    p_d           = p_q;
    d_d           = d_q;
    shadow_d      = shadow_q;
    dig_sel_d     = '0;
    seg_d         = '0;
    frame_start_d = 1'b0;
    if (!enable) begin
      p_d      = '0;
      d_d      = '0;
      shadow_d = value;
    end else begin
      if (p_q == P_LAST) begin
        p_d = '0;
        if (d_q == D_LAST) begin
          d_d           = '0;
          shadow_d      = value;
          frame_start_d = 1'b1;
        end else begin
          d_d = d_q + 1'b1;
        end
      end else begin
        p_d = p_q + 1'b1;
      end
      // Outputs are decoded from the pre-update state, so they trail it by one clock.
      if (!in_guard && !lzb_blank) begin
        dig_sel_d = NDIG'(1) << d_q;
        seg_d     = nib_seg;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      p_q           <= '0;
      d_q           <= '0;
      shadow_q      <= '0;
      dig_sel_q     <= '0;
      seg_q         <= '0;
      frame_start_q <= 1'b0;
    end else begin
      p_q           <= p_d;
      d_q           <= d_d;
      shadow_q      <= shadow_d;
      dig_sel_q     <= dig_sel_d;
      seg_q         <= seg_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign dig_sel     = dig_sel_q;
  assign seg         = seg_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_hexdisp_scan.sv
// Bench for hexdisp_scan (NDIG=8, DIV=4, GUARD=1) against a time-indexed display model.
module tb_hexdisp_scan;

  localparam int NDIG  = 8;
  localparam int DIV   = 4;
  localparam int GUARD = 1;
  localparam int FRAME = NDIG * DIV;

  logic        clock  = 1'b0;
  logic        reset  = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] value  = '0;
  logic [7:0]  dig_sel;
  logic [7:0]  seg;
  logic        frame_start;

  int checks = 0;
  int errors = 0;

  // n = enabled clock edges since the scan (re)started; exp_q[f] = value shown in frame f
  int          n = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  exp_dig;
  logic [7:0]  exp_seg;
  logic        exp_fs;

  always #5 clock = ~clock;

  hexdisp_scan #(.NDIG(NDIG), .DIV(DIV), .GUARD(GUARD)) dut (
    .clock       (clock),
    .reset       (reset),
    .value       (value),
    .enable      (enable),
    .dig_sel     (dig_sel),
    .seg         (seg),
    .frame_start (frame_start)
  );

  function automatic logic [6:0] seg_ref(input logic [3:0] h);
    case (h)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    int t, p, d, f;
    logic [31:0] sh, up;
    bit lit;
    if (!reset || !enable) begin
      n = 0;
      exp_q.delete();
      exp_q.push_back(reset ? value : 32'h0);
      exp_dig = '0;
      exp_seg = '0;
      exp_fs  = 1'b0;
    end else begin
      n++;
      if (n % FRAME == 0) exp_q.push_back(value);
      t   = n - 1;
      p   = t % DIV;
      d   = (t / DIV) % NDIG;
      f   = t / FRAME;
      sh  = exp_q[f];
      up  = sh >> (4 * d);
      lit = (p >= GUARD);
`ifdef HEXDISP_LZB_EN
      if (d > 0 && up == 0) lit = 1'b0;
`endif
      exp_dig = lit ? 8'(1 << d) : 8'h00;
      exp_seg = lit ? {1'b0, seg_ref(up[3:0])} : 8'h00;
      exp_fs  = (n % FRAME == 0);
    end
  endtask

  task automatic step(input string tag);
    @(posedge clock);
    model_edge();
    #1;
    chk({tag, ".dig_sel"}, 32'(dig_sel), 32'(exp_dig));
    chk({tag, ".seg"}, 32'(seg), 32'(exp_seg));
    chk({tag, ".frame_start"}, 32'(frame_start), 32'(exp_fs));
  endtask

  task automatic run(input int cycles, input string tag);
    for (int i = 0; i < cycles; i++) step(tag);
  endtask

  // Step until the scan state (after the latest edge) is digit dt, prescaler pt.
  task automatic run_until(input int dt, input int pt, input string tag);
    bit found = 0;
    for (int i = 0; i < 4 * FRAME && !found; i++) begin
      step(tag);
      if (((n / DIV) % NDIG) == dt && (n % DIV) == pt) found = 1;
    end
    chk({tag, ".reached"}, 32'(found), 32'd1);
  endtask

  initial begin
    exp_q.push_back('0);
    enable = 1'b1;
    value  = 32'h1234ABCD;

    // Reset held with enable high
    #1;
    chk("rst_async.dig_sel", 32'(dig_sel), 32'h0);
    chk("rst_async.seg", 32'(seg), 32'h0);
    run(3, "rst_hold");
    reset = 1'b1;
    step("rst_rel0");
    step("rst_rel1");
    chk("rst_first_lit.dig_sel", 32'(dig_sel), 32'h01);
    chk("rst_first_lit.seg", 32'(seg), 32'h3F);
    run(2 * FRAME + 4, "post_rst");

    // Steady scan order
    value = 32'h89ABCDEF;
    run(3 * FRAME, "scan");

    // No tearing: change value mid-frame
    value = 32'h11111111;
    run_until(0, 0, "tear_sync");
    run_until(3, 1, "tear_d3");
    value = 32'h22222222;
    run(2 * FRAME, "tear");

    // Enable toggle
    value = 32'h5A5A5A5A;
    run_until(5, 0, "en_d5");
    enable = 1'b0;
    step("en_off");
    chk("en_off_dark.dig_sel", 32'(dig_sel), 32'h0);
    run(3, "en_off_hold");
    value = 32'h0000000F;
    step("en_off_load");
    enable = 1'b1;
    step("en_on0");
    step("en_on1");
    chk("en_on_first.dig_sel", 32'(dig_sel), 32'h01);
    chk("en_on_first.seg", 32'(seg), 32'h71);
    run(FRAME + 8, "en_on");

    // Leading zeros (blanked only with HEXDISP_LZB_EN)
    enable = 1'b0;
    value  = 32'h000000A5;
    step("lzb_load");
    enable = 1'b1;
    run(2 * FRAME, "lzb");

    // Randomised value changes and enable drops
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) value = $urandom;
      if ($urandom_range(0, 59) == 0) enable = ~enable;
      else if (!enable && $urandom_range(0, 3) == 0) enable = 1'b1;
      step("rand");
    end
    enable = 1'b1;

    // Async reset mid-slot at d=6, p=2
    run_until(6, 2, "arst_pos");
    #3;
    reset = 1'b0;
    #1;
    chk("arst_now.dig_sel", 32'(dig_sel), 32'h0);
    chk("arst_now.seg", 32'(seg), 32'h0);
    chk("arst_now.frame_start", 32'(frame_start), 32'h0);
    run(2, "arst_hold");
    reset = 1'b1;
    value = 32'hFEDCBA98;
    run(2 * FRAME, "arst_after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
